// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle control path.
// Contents:
//   - opcode field values for every instruction class the core executes
//   - 3-bit FSM state encodings
//   - pc_sel, wb_sel and trap_cause codes
//   - small per-opcode decode helpers used by the control FSM
package multicycle_ctrl_pkg;

    // Opcode field values (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // FSM state encodings
    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_EXECUTE = 3'd2;
    localparam logic [2:0] ST_MEM     = 3'd3;
    localparam logic [2:0] ST_WB      = 3'd4;
    localparam logic [2:0] ST_TRAP    = 3'd5;

    // Next-PC source
    localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SEL_IMM   = 2'b01;
    localparam logic [1:0] PC_SEL_ALU   = 2'b10;

    // Register write-back source
    localparam logic [1:0] WB_SEL_ALU   = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4   = 2'b10;
    localparam logic [1:0] WB_SEL_IMM   = 2'b11;

    // Trap cause codes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Width of the bus wait timer
    localparam int TIMER_W = 8;

    // ALU operand selects: a_pc picks pc over rs1, b_imm picks imm over rs2
    typedef struct packed {
        logic a_pc;
        logic b_imm;
    } alu_sel_t;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_OP, OP_OP_IMM, OP_LUI, OP_AUIPC: is_legal_opcode = 1'b1;
            default:                           is_legal_opcode = 1'b0;
        endcase
    endfunction

    // pc is operand A whenever the ALU forms a pc-relative target;
    // rs2 is operand B only for register-register ALU ops.
    function automatic alu_sel_t alu_sel_for(input logic [6:0] op);
        alu_sel_t s;
        s.a_pc  = (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_BRANCH);
        s.b_imm = (op != OP_OP);
        return s;
    endfunction

    function automatic logic [1:0] wb_sel_for(input logic [6:0] op);
        case (op)
            OP_LOAD:         wb_sel_for = WB_SEL_LOAD;
            OP_JAL, OP_JALR: wb_sel_for = WB_SEL_PC4;
            OP_LUI:          wb_sel_for = WB_SEL_IMM;
            default:         wb_sel_for = WB_SEL_ALU;
        endcase
    endfunction

    function automatic logic [1:0] wb_pc_sel_for(input logic [6:0] op);
        case (op)
            OP_JAL:  wb_pc_sel_for = PC_SEL_IMM;
            OP_JALR: wb_pc_sel_for = PC_SEL_ALU;
            default: wb_pc_sel_for = PC_SEL_PLUS4;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Bus wait timer for the multi-cycle control FSM.
// Counts cycles spent waiting for a memory acknowledge and flags the cycle
// in which the wait reaches TIMEOUT cycles.
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   clr      in   clear the count (state change)
//   en       in   this cycle is a wait cycle (request pending, no ack)
//   expired  out  this wait cycle is the TIMEOUT-th one
module multicycle_ctrl_wait_timer
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // The count holds the number of wait cycles already completed, so the
    // TIMEOUT-th wait cycle is the one that sees TIMEOUT-1.
    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SAT   = '1;

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count_q <= '0;
        end else if (en && (count_q != SAT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = en && (count_q >= LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB) around the external
// combinational decoder, handshakes with instruction/data memory, drives the
// datapath strobes and muxes, traps illegal opcodes and bus timeouts, and
// counts retired instructions.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   opcode                      instr[6:0] from the instruction register
//   branch_taken                branch compare result (used in EXECUTE)
//   imem_req / imem_ack         instruction fetch handshake
//   dmem_req / dmem_we / dmem_ack  data access handshake
//   ir_we                       latch instruction register (Mealy on imem_ack)
//   pc_we, pc_sel               PC update strobe and next-PC source
//   alu_a_sel, alu_b_sel        ALU operand selects
//   reg_we, wb_sel              register write strobe and source
//   trap, trap_cause            sticky halt flag and reason
//   instret                     retired instruction count (wraps)
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    logic [2:0]  state_q, state_d;
    logic [6:0]  opc_q;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] instret_q;
    logic        timer_en, timer_clr, timer_expired;
    alu_sel_t    alu_sel;

    // Waiting means a request is outstanding and its ack has not arrived.
    assign timer_en  = ((state_q == ST_FETCH) && !imem_ack) ||
                       ((state_q == ST_MEM)   && !dmem_ack);
    assign timer_clr = (state_d != state_q);

    multicycle_ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_FETCH: begin
                // An ack in the expiry cycle still completes the fetch.
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (is_legal_opcode(opcode)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXECUTE: begin
                if (opc_q == OP_BRANCH) begin
                    state_d = ST_FETCH;
                end else if ((opc_q == OP_LOAD) || (opc_q == OP_STORE)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = (opc_q == OP_STORE) ? ST_FETCH : ST_WB;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            // Unused encodings fall back to a fresh fetch.
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cause_q <= CAUSE_NONE;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            // Snapshot the opcode once the IR is stable so later states do
            // not depend on the decoder path staying quiet.
            if (state_q == ST_DECODE) begin
                opc_q <= opcode;
            end
        end
    end

    assign alu_sel = alu_sel_for(opc_q);

    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = WB_SEL_ALU;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            ST_EXECUTE: begin
                alu_a_sel = alu_sel.a_pc;
                alu_b_sel = alu_sel.b_imm;
                if (opc_q == OP_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                end
            end
            ST_MEM: begin
                // Operand selects stay put so the address seen by memory
                // does not move while the access is pending.
                alu_a_sel = alu_sel.a_pc;
                alu_b_sel = alu_sel.b_imm;
                dmem_req  = 1'b1;
                dmem_we   = (opc_q == OP_STORE);
                if ((opc_q == OP_STORE) && dmem_ack) begin
                    pc_we = 1'b1;
                end
            end
            ST_WB: begin
                // JALR takes its target from the ALU here, so keep the
                // operand selects valid through write-back.
                alu_a_sel = alu_sel.a_pc;
                alu_b_sel = alu_sel.b_imm;
                reg_we    = 1'b1;
                pc_we     = 1'b1;
                wb_sel    = wb_sel_for(opc_q);
                pc_sel    = wb_pc_sel_for(opc_q);
            end
            default: begin
            end
        endcase
    end

    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;

    // One instruction retires on every PC update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (pc_we) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;

endmodule
